// File: rtl/mux4_rr_arbiter_pkg.sv
// rtl/mux4_rr_arbiter_pkg.sv - shared encodings and round-robin search helper for mux4_rr_arbiter
package mux4_rr_arbiter_pkg;

   localparam int NUM_LANES = 4;
   localparam int SEL_W     = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Returns {found, lane}; searches last+1, last+2, ... with last itself as lowest priority.
   function automatic logic [SEL_W:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                              input logic [SEL_W-1:0]     last);
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] idx;
      res = '0;
      for (int k = NUM_LANES; k >= 1; k--) begin
         idx = last + SEL_W'(k);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - request/data/grant bundle between four producer lanes and the arbiter
interface mux4_rr_arbiter_if #(parameter int DATA_W = 8);
   logic [3:0]        i_req;
   logic [DATA_W-1:0] i_d0;
   logic [DATA_W-1:0] i_d1;
   logic [DATA_W-1:0] i_d2;
   logic [DATA_W-1:0] i_d3;
   logic [3:0]        o_grant;
   logic [1:0]        o_sel;
   logic              o_valid;
   logic [DATA_W-1:0] o_dout;

   modport master (output i_req, i_d0, i_d1, i_d2, i_d3,
                   input  o_grant, o_sel, o_valid, o_dout);
   modport slave  (input  i_req, i_d0, i_d1, i_d2, i_d3,
                   output o_grant, o_sel, o_valid, o_dout);
endinterface

// File: rtl/mux4_lane_sel.sv
// rtl/mux4_lane_sel.sv - DATA_W-wide 4:1 lane mux indexed by the registered select
module mux4_lane_sel #(
   parameter int DATA_W = 8
) (
   input  logic [1:0]        i_sel,
   input  logic [DATA_W-1:0] i_d0,
   input  logic [DATA_W-1:0] i_d1,
   input  logic [DATA_W-1:0] i_d2,
   input  logic [DATA_W-1:0] i_d3,
   output logic [DATA_W-1:0] o_dout
);

   always_comb begin
      o_dout = i_d0;
      case (i_sel)
         2'd0:    o_dout = i_d0;
         2'd1:    o_dout = i_d1;
         2'd2:    o_dout = i_d2;
         default: o_dout = i_d3;
      endcase
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving a shared 4:1 data mux
// Optional HOLD_LIMIT_EN: caps a tenure at MAX_HOLD cycles when another lane is waiting.
module mux4_rr_arbiter
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic           i_clk,
   input  logic           i_rst,
   mux4_rr_arbiter_if.slave bus
);

   state_t               r_state;
   logic [NUM_LANES-1:0] r_grant;
   logic [SEL_W-1:0]     r_sel;
   logic                 r_valid;
   logic [SEL_W-1:0]     r_last;

   state_t               w_state_nxt;
   logic [NUM_LANES-1:0] w_grant_nxt;
   logic [SEL_W-1:0]     w_sel_nxt;
   logic                 w_valid_nxt;
   logic [SEL_W-1:0]     w_last_nxt;
   logic                 w_new_tenure;
   logic [NUM_LANES-1:0] w_others;
   logic [NUM_LANES-1:0] w_cand;
   logic                 w_found;
   logic [SEL_W-1:0]     w_pick;
   logic                 w_force;
   logic [DATA_W-1:0]    w_mux;

   assign w_others          = bus.i_req & ~(NUM_LANES'(1) << r_sel);
   // While busy, r_sel is masked so the current owner never re-wins its own handoff.
   assign w_cand            = (r_state == ST_BUSY) ? w_others : bus.i_req;
   assign {w_found, w_pick} = rr_pick(w_cand, r_last);

`ifdef HOLD_LIMIT_EN
   localparam int HC_W = $clog2(MAX_HOLD + 1);
   logic [HC_W-1:0] r_hold_cnt;

   assign w_force = (r_hold_cnt == HC_W'(MAX_HOLD)) && (|w_others);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hold_cnt <= '0;
      end else if (w_new_tenure) begin
         r_hold_cnt <= HC_W'(1);
      end else if (w_state_nxt == ST_IDLE) begin
         r_hold_cnt <= '0;
      end else if (r_hold_cnt != HC_W'(MAX_HOLD)) begin
         r_hold_cnt <= r_hold_cnt + HC_W'(1);
      end
   end
`else
   assign w_force = 1'b0;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_sel_nxt    = r_sel;
      w_valid_nxt  = r_valid;
      w_last_nxt   = r_last;
      w_new_tenure = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt  = ST_BUSY;
               w_grant_nxt  = NUM_LANES'(1) << w_pick;
               w_sel_nxt    = w_pick;
               w_valid_nxt  = 1'b1;
               w_last_nxt   = w_pick;
               w_new_tenure = 1'b1;
            end
         end
         default: begin
            if (bus.i_req[r_sel] && !w_force) begin
               w_state_nxt = ST_BUSY;
            end else if (w_found) begin
               w_grant_nxt  = NUM_LANES'(1) << w_pick;
               w_sel_nxt    = w_pick;
               w_last_nxt   = w_pick;
               w_new_tenure = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = '0;
               w_valid_nxt = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_sel   <= '0;
         r_valid <= 1'b0;
         r_last  <= SEL_W'(NUM_LANES - 1);
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_sel   <= w_sel_nxt;
         r_valid <= w_valid_nxt;
         r_last  <= w_last_nxt;
      end
   end

   mux4_lane_sel #(.DATA_W(DATA_W)) u_lane_sel (
      .i_sel  (r_sel),
      .i_d0   (bus.i_d0),
      .i_d1   (bus.i_d1),
      .i_d2   (bus.i_d2),
      .i_d3   (bus.i_d3),
      .o_dout (w_mux)
   );

   assign bus.o_grant = r_grant;
   assign bus.o_sel   = r_sel;
   assign bus.o_valid = r_valid;
   assign bus.o_dout  = r_valid ? w_mux : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard bench for mux4_rr_arbiter (honours HOLD_LIMIT_EN)
module tb_mux4_rr_arbiter;

   localparam int DATA_W   = 8;
   localparam int MAX_HOLD = 4;
`ifdef HOLD_LIMIT_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   typedef struct {
      logic [3:0] grant;
      logic [1:0] sel;
      logic       valid;
   } exp_t;

   logic              clk;
   logic              rst_v;
   logic [3:0]        req_v;
   logic [DATA_W-1:0] d_v [4];
   bit                rand_data;

   exp_t exp_q[$];
   int   n_cmp;
   int   n_bad;

   int         m_owner;
   int         m_last;
   int         m_hold;
   logic [1:0] m_sel;

   mux4_rr_arbiter_if #(.DATA_W(DATA_W)) ifc ();

   assign ifc.i_req = req_v;
   assign ifc.i_d0  = d_v[0];
   assign ifc.i_d1  = d_v[1];
   assign ifc.i_d2  = d_v[2];
   assign ifc.i_d3  = d_v[3];

   mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
      .i_clk (clk),
      .i_rst (rst_v),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = 3;
      m_hold  = 0;
      m_sel   = 2'd0;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
      e.sel   = m_sel;
      e.valid = (m_owner >= 0);
      return e;
   endfunction

   // One clock edge of the arbitration rules applied to the sampled request vector.
   task automatic model_step(input logic [3:0] r);
      bit others;
      int win;
      others = 1'b0;
      for (int i = 0; i < 4; i++)
         if (r[i] && i != m_owner) others = 1'b1;
      if (m_owner >= 0 && r[m_owner] && !(HOLD && m_hold == MAX_HOLD && others)) begin
         if (m_hold < MAX_HOLD) m_hold++;
      end else begin
         win = -1;
         for (int k = 1; k <= 4; k++) begin
            int lane;
            lane = (m_last + k) % 4;
            if (win < 0 && r[lane] && lane != m_owner) win = lane;
         end
         if (win >= 0) begin
            m_owner = win;
            m_last  = win;
            m_hold  = 1;
            m_sel   = 2'(win);
         end else begin
            m_owner = -1;
            m_hold  = 0;
         end
      end
   endtask

   task automatic drive_data();
      for (int i = 0; i < 4; i++)
         d_v[i] = rand_data ? 8'($urandom) : 8'(8'hA0 + i);
   endtask

   // Account for the edge that samples the current inputs, then apply the next ones.
   task automatic cyc(input logic [3:0] r, input logic rst_next);
      @(posedge clk);
      if (rst_v) model_reset();
      else       model_step(req_v);
      exp_q.push_back(model_out());
      #1;
      req_v = r;
      rst_v = rst_next;
      drive_data();
   endtask

   task automatic pulse_rst();
      @(posedge clk);
      if (rst_v) model_reset();
      else       model_step(req_v);
      exp_q.push_back(model_out());
      #1;
      rst_v = 1'b1;
      exp_q.delete();
      model_reset();
      exp_q.push_back(model_out());
      #1;
      chk("async_grant", 32'(ifc.o_grant), 32'd0);
      chk("async_valid", 32'(ifc.o_valid), 32'd0);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [7:0] exp_dout;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_dout = e.valid ? d_v[e.sel] : 8'd0;
            chk("grant",  32'(ifc.o_grant), 32'(e.grant));
            chk("sel",    32'(ifc.o_sel),   32'(e.sel));
            chk("valid",  32'(ifc.o_valid), 32'(e.valid));
            chk("dout",   32'(ifc.o_dout),  32'(exp_dout));
            chk("onehot", 32'($onehot0(ifc.o_grant)), 32'd1);
         end
      end
   end

   initial begin : stimulus
      logic [3:0] r;
      n_cmp     = 0;
      n_bad     = 0;
      rst_v     = 1'b1;
      req_v     = 4'd0;
      rand_data = 1'b0;
      model_reset();
      drive_data();

      cyc(4'd0, 1'b1);
      cyc(4'd0, 1'b0);
      repeat (5) cyc(4'd0, 1'b0);

      repeat (4) cyc(4'b1111, 1'b0);
      repeat (3) cyc(4'b1110, 1'b0);
      repeat (2) cyc(4'b0000, 1'b0);

      cyc(4'b1111, 1'b0);
      cyc(4'b1110, 1'b0);
      cyc(4'b1100, 1'b0);
      cyc(4'b1000, 1'b0);
      cyc(4'b0001, 1'b0);
      repeat (2) cyc(4'b0000, 1'b0);

      pulse_rst();
      cyc(4'b1001, 1'b0);
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
      cyc(4'b1001, 1'b0);
      repeat (2) cyc(4'b0000, 1'b0);

      repeat (20) cyc(4'b0011, 1'b0);
      repeat (2) cyc(4'b0000, 1'b0);

      repeat (3) cyc(4'b0100, 1'b0);
      pulse_rst();
      cyc(4'b0101, 1'b0);
      cyc(4'b0101, 1'b0);
      repeat (2) cyc(4'b0000, 1'b0);

      rand_data = 1'b1;
      r = 4'd0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom);
         if ($urandom_range(0, 149) == 0) begin
            pulse_rst();
            cyc(r, 1'b0);
         end else begin
            cyc(r, 1'b0);
         end
      end

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
